// File: rtl/counter_run_sched.sv
// counter_run_sched
//   Round-robin scheduler for a single shared run-counter. The arbiter picks
//   one requester from i_req, latches its run length and steps the counter
//   through IDLE -> RUN -> DONE. The owner is held in o_gnt for the whole run
//   and gets a one-cycle o_done pulse at the end.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no owner; arbitrate, latch owner and run length on a request
//   RUN   | o_cnt counts 0 .. num_q-1, one step per cycle
//   DONE  | one cycle; o_done[owner] pulses, owner becomes lowest priority
//
// Ports
//   clk      system clock, all logic on posedge
//   reset_n  synchronous active-low reset
//   i_req    per-requester run request (level)
//   i_num    run lengths, requester k at [k*CNT_W +: CNT_W]
//   o_gnt    one-hot grant, high in RUN and DONE
//   o_done   one-hot one-cycle pulse in DONE
//   o_owner  index of the current or last owner
//   o_cnt    current count value
//   o_busy   state is not IDLE
module counter_run_sched #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 4,
  localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*CNT_W-1:0] i_num,
  output logic [NREQ-1:0]       o_gnt,
  output logic [NREQ-1:0]       o_done,
  output logic [OW-1:0]         o_owner,
  output logic [CNT_W-1:0]      o_cnt,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      ptr_q,   ptr_d;
  logic [CNT_W-1:0]   num_q,   num_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic               pick_valid;
  logic [OW-1:0]      pick_idx;
  logic [OW-1:0]      scan_idx;
  logic [CNT_W-1:0]   num_sel;

  // Round-robin search starting just above ptr_q. Scanning offsets from the
  // far end down lets the nearest set bit overwrite earlier hits.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int off = NREQ; off >= 1; off--) begin
      scan_idx = OW'((int'(ptr_q) + off) % NREQ);
      if (i_req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    num_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_idx == OW'(k)) num_sel = i_num[k*CNT_W +: CNT_W];
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_valid) begin
          owner_d = pick_idx;
          num_d   = num_sel;
          // A zero-length run skips RUN entirely.
          state_d = (num_sel != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (cnt_q == num_q - CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        ptr_d   = owner_q;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= OW'(NREQ - 1);
      num_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    o_gnt  = '0;
    o_done = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (owner_q == OW'(k)) begin
        o_gnt[k]  = (state_q == RUN) || (state_q == DONE);
        o_done[k] = (state_q == DONE);
      end
    end
  end

  assign o_owner = owner_q;
  assign o_cnt   = cnt_q;
  assign o_busy  = (state_q != IDLE);

endmodule
